// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the timed-level scoreboard controller.
package scoreboard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_EVAL = 3'd2,
        ST_LOAD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

    // Pass threshold for a level; clamped at zero for small levels.
    function automatic int unsigned pass_threshold(input int unsigned level,
                                                   input int unsigned step,
                                                   input int unsigned offset);
        if (level * step > offset)
            return level * step - offset;
        else
            return 0;
    endfunction

endpackage

// File: rtl/scoreboard_ctrl_param_bcd_sat_adder.sv
// Combinational multi-digit BCD adder of a single-digit addend; clamps to all-9s on overflow.
module bcd_sat_adder
    import scoreboard_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [3:0]          addend,
    output logic [4*DIGITS-1:0] sum,
    output logic                sat
);

    logic [DIGITS:0]     carry;
    logic [4*DIGITS-1:0] raw_sum;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] add_in;
            logic [4:0] raw;
            logic [3:0] adj;

            assign add_in = (gi == 0) ? addend : 4'd0;
            assign raw    = {1'b0, a[gi*4 +: 4]} + {1'b0, add_in} + {4'd0, carry[gi]};
            // raw is 10..19 whenever a carry is produced, so the low nibble minus 10 is exact mod 16
            assign adj    = raw[3:0] - 4'd10;
            assign carry[gi+1] = (raw > 5'd9);
            assign raw_sum[gi*4 +: 4] = carry[gi+1] ? adj : raw[3:0];
            assign sum[gi*4 +: 4]     = sat ? BCD_NINE : raw_sum[gi*4 +: 4];
        end
    endgenerate

    assign sat = carry[DIGITS];

endmodule

// File: rtl/scoreboard_ctrl_param.sv
// Timed-level scoreboard: 1 s prescaler, BCD countdown, saturating BCD score, level pass gating.
module scoreboard_ctrl_param
    import scoreboard_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TIME_SECS     = 60,
    parameter int PTS_DIGITS    = 3,
    parameter int NUM_LEVELS    = 2,
    parameter int PTS_NORMAL    = 2,
    parameter int PTS_BONUS     = 3,
    parameter int BONUS_SECS    = 15,
    parameter int PASS_STEP     = 100,
    parameter int PASS_OFFSET   = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st,
    input  logic                    pt,
    input  logic                    pause,
    output logic [4*PTS_DIGITS-1:0] score_bcd,
    output logic [7:0]              timer_bcd,
    output logic [3:0]              level_bcd,
    output logic                    running,
    output logic                    done,
    output logic                    win
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SW = $clog2(10 ** PTS_DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SCORE_MAX = SW'(10 ** PTS_DIGITS - 1);
    localparam logic [7:0]    TIME_BCD  = {4'(TIME_SECS / 10), 4'(TIME_SECS % 10)};

    state_t                  state_reg, state_next;
    logic [4*PTS_DIGITS-1:0] score_reg, score_next;
    logic [SW-1:0]           shadow_reg, shadow_next;
    logic [7:0]              timer_reg, timer_next;
    logic [3:0]              level_reg, level_next;
    logic [PW-1:0]           presc_reg, presc_next;
    logic                    done_reg, done_next;
    logic                    win_reg, win_next;
    logic                    advance_reg, advance_next;

    logic [6:0]              timer_bin;
    logic [3:0]              amount;
    logic [4*PTS_DIGITS-1:0] score_sum;
    logic                    score_sat;
    logic [SW-1:0]           shadow_sum;
    logic [7:0]              timer_dec;
    logic                    tick;
    logic                    pass;

    // Bonus decision uses the timer value before this cycle's tick
    assign timer_bin  = 7'(timer_reg[7:4]) * 7'd10 + 7'(timer_reg[3:0]);
    assign amount     = (32'(timer_bin) <= BONUS_SECS) ? 4'(PTS_BONUS) : 4'(PTS_NORMAL);
    assign shadow_sum = score_sat ? SCORE_MAX : shadow_reg + SW'(amount);
    assign timer_dec  = (timer_reg[3:0] == 4'd0) ? {timer_reg[7:4] - 4'd1, 4'd9}
                                                 : {timer_reg[7:4], timer_reg[3:0] - 4'd1};
    assign tick       = !pause && (presc_reg == PRESC_MAX);
    assign pass       = 32'(shadow_reg) >= pass_threshold(32'(level_reg), PASS_STEP, PASS_OFFSET);

    bcd_sat_adder #(
        .DIGITS (PTS_DIGITS)
    ) u_adder (
        .a      (score_reg),
        .addend (amount),
        .sum    (score_sum),
        .sat    (score_sat)
    );

    always_comb begin
        state_next   = state_reg;
        score_next   = score_reg;
        shadow_next  = shadow_reg;
        timer_next   = timer_reg;
        level_next   = level_reg;
        presc_next   = presc_reg;
        done_next    = done_reg;
        win_next     = win_reg;
        advance_next = advance_reg;

        case (state_reg)
            ST_IDLE: begin
                if (st) begin
                    state_next   = ST_LOAD;
                    advance_next = 1'b0;
                end
            end
            ST_LOAD: begin
                if (advance_reg) begin
                    level_next = level_reg + 4'd1;
                end else begin
                    score_next  = '0;
                    shadow_next = '0;
                    level_next  = 4'd1;
                end
                timer_next   = TIME_BCD;
                presc_next   = '0;
                done_next    = 1'b0;
                win_next     = 1'b0;
                advance_next = 1'b0;
                state_next   = ST_RUN;
            end
            ST_RUN: begin
                if (pt) begin
                    score_next  = score_sum;
                    shadow_next = shadow_sum;
                end
                if (!pause)
                    presc_next = tick ? '0 : presc_reg + 1'b1;
                if (tick) begin
                    timer_next = timer_dec;
                    if (timer_reg == 8'h01)
                        state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (pass && (32'(level_reg) < NUM_LEVELS)) begin
                    state_next   = ST_LOAD;
                    advance_next = 1'b1;
                end else begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                    win_next   = pass;
                end
            end
            ST_DONE: begin
                if (st) begin
                    state_next   = ST_LOAD;
                    advance_next = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            score_reg   <= '0;
            shadow_reg  <= '0;
            timer_reg   <= TIME_BCD;
            level_reg   <= 4'd1;
            presc_reg   <= '0;
            done_reg    <= 1'b0;
            win_reg     <= 1'b0;
            advance_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            score_reg   <= score_next;
            shadow_reg  <= shadow_next;
            timer_reg   <= timer_next;
            level_reg   <= level_next;
            presc_reg   <= presc_next;
            done_reg    <= done_next;
            win_reg     <= win_next;
            advance_reg <= advance_next;
        end
    end

    assign score_bcd = score_reg;
    assign timer_bcd = timer_reg;
    assign level_bcd = level_reg;
    assign running   = (state_reg == ST_RUN);
    assign done      = done_reg;
    assign win       = win_reg;

endmodule

// File: tb/tb_scoreboard_ctrl_param.sv
// Directed bench: 4-cycle seconds, 10 s levels, two levels, bonus window at <=3 s.
module tb_scoreboard_ctrl_param;

    logic        clk = 1'b0;
    logic        rst, st, pt, pause;
    logic [11:0] score_bcd;
    logic [7:0]  timer_bcd;
    logic [3:0]  level_bcd;
    logic        running, done, win;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scoreboard_ctrl_param #(
        .TICKS_PER_SEC (4),
        .TIME_SECS     (10),
        .PTS_DIGITS    (3),
        .NUM_LEVELS    (2),
        .PTS_NORMAL    (2),
        .PTS_BONUS     (3),
        .BONUS_SECS    (3),
        .PASS_STEP     (100),
        .PASS_OFFSET   (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .st        (st),
        .pt        (pt),
        .pause     (pause),
        .score_bcd (score_bcd),
        .timer_bcd (timer_bcd),
        .level_bcd (level_bcd),
        .running   (running),
        .done      (done),
        .win       (win)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_timer(input logic [7:0] v, input int budget);
        int n = 0;
        while (timer_bcd !== v && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (timer_bcd !== v) begin
            failures++;
            $display("FAIL wait_timer: timer=%h required %h within %0d cycles", timer_bcd, v, budget);
        end
    endtask

    task automatic wait_running(input logic v, input int budget);
        int n = 0;
        while (running !== v && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (running !== v) begin
            failures++;
            $display("FAIL wait_running: running=%b required %b within %0d cycles", running, v, budget);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wait_done: done=%b required 1 within %0d cycles", done, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; st = 1'b0; pt = 1'b0; pause = 1'b0;
        step(2);
        rst = 1'b0;
        checks++; if (score_bcd !== 12'h000) begin failures++; $display("FAIL reset_score: got %h want 000", score_bcd); end
        checks++; if (timer_bcd !== 8'h10) begin failures++; $display("FAIL reset_timer: got %h want 10", timer_bcd); end
        checks++; if (level_bcd !== 4'h1) begin failures++; $display("FAIL reset_level: got %h want 1", level_bcd); end
        checks++; if ({running, done, win} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {running, done, win}); end
        pt = 1'b1; step(1); pt = 1'b0;
        checks++; if (score_bcd !== 12'h000 || running !== 1'b0) begin failures++; $display("FAIL idle_pt: score=%h running=%b want 000/0", score_bcd, running); end
        $display("test_reset: done");
    endtask

    task automatic test_start();
        st = 1'b1; step(1); st = 1'b0;
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL start_load: running=%b want 0", running); end
        step(1);
        checks++; if (running !== 1'b1 || timer_bcd !== 8'h10 || level_bcd !== 4'h1 || score_bcd !== 12'h000) begin
            failures++; $display("FAIL start_run: run=%b timer=%h level=%h score=%h want 1/10/1/000", running, timer_bcd, level_bcd, score_bcd);
        end
        step(3);
        checks++; if (timer_bcd !== 8'h10) begin failures++; $display("FAIL first_tick_early: timer=%h want 10", timer_bcd); end
        step(1);
        checks++; if (timer_bcd !== 8'h09) begin failures++; $display("FAIL first_tick: timer=%h want 09", timer_bcd); end
        $display("test_start: done");
    endtask

    task automatic test_bonus_pause();
        wait_timer(8'h05, 100);
        pt = 1'b1; step(1); pt = 1'b0;
        checks++; if (score_bcd !== 12'h002) begin failures++; $display("FAIL normal_pts: score=%h want 002", score_bcd); end
        wait_timer(8'h03, 100);
        pt = 1'b1; step(1); pt = 1'b0;
        checks++; if (score_bcd !== 12'h005) begin failures++; $display("FAIL bonus_pts: score=%h want 005", score_bcd); end
        pause = 1'b1; pt = 1'b1; step(14); pt = 1'b0;
        checks++; if (score_bcd !== 12'h047) begin failures++; $display("FAIL pause_pts: score=%h want 047", score_bcd); end
        checks++; if (timer_bcd !== 8'h03) begin failures++; $display("FAIL pause_timer: timer=%h want 03", timer_bcd); end
        pause = 1'b0;
        $display("test_bonus_pause: done");
    endtask

    task automatic test_final_tick();
        wait_timer(8'h01, 100);
        step(3);
        pt = 1'b1; step(1); pt = 1'b0;
        checks++; if (timer_bcd !== 8'h00 || score_bcd !== 12'h050) begin
            failures++; $display("FAIL final_tick_pt: timer=%h score=%h want 00/050", timer_bcd, score_bcd);
        end
        checks++; if (running !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL eval_flags: running=%b done=%b want 0/0", running, done); end
        $display("test_final_tick: done");
    endtask

    task automatic test_level_up();
        step(1);
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL load_lvl2: running=%b want 0", running); end
        step(1);
        checks++; if (level_bcd !== 4'h2 || timer_bcd !== 8'h10 || score_bcd !== 12'h050 || running !== 1'b1) begin
            failures++; $display("FAIL level_up: level=%h timer=%h score=%h run=%b want 2/10/050/1", level_bcd, timer_bcd, score_bcd, running);
        end
        step(5);
        st = 1'b1; step(1); st = 1'b0;
        checks++; if (level_bcd !== 4'h2 || timer_bcd !== 8'h09 || running !== 1'b1) begin
            failures++; $display("FAIL st_in_run: level=%h timer=%h run=%b want 2/09/1", level_bcd, timer_bcd, running);
        end
        $display("test_level_up: done");
    endtask

    task automatic test_final_lose();
        wait_done(100);
        checks++; if (win !== 1'b0 || score_bcd !== 12'h050 || level_bcd !== 4'h2 || timer_bcd !== 8'h00) begin
            failures++; $display("FAIL lose: win=%b score=%h level=%h timer=%h want 0/050/2/00", win, score_bcd, level_bcd, timer_bcd);
        end
        pt = 1'b1; step(1); pt = 1'b0;
        checks++; if (score_bcd !== 12'h050 || done !== 1'b1) begin failures++; $display("FAIL done_hold: score=%h done=%b want 050/1", score_bcd, done); end
        $display("test_final_lose: done");
    endtask

    task automatic test_final_win();
        st = 1'b1; step(1); st = 1'b0; step(1);
        checks++; if (level_bcd !== 4'h1 || score_bcd !== 12'h000 || {done, win} !== 2'b00 || timer_bcd !== 8'h10) begin
            failures++; $display("FAIL restart: level=%h score=%h dw=%b timer=%h want 1/000/00/10", level_bcd, score_bcd, {done, win}, timer_bcd);
        end
        pause = 1'b1; pt = 1'b1; step(25); pt = 1'b0; pause = 1'b0;
        checks++; if (score_bcd !== 12'h050) begin failures++; $display("FAIL win_l1_score: score=%h want 050", score_bcd); end
        wait_running(1'b0, 100);
        step(2);
        checks++; if (level_bcd !== 4'h2 || score_bcd !== 12'h050) begin failures++; $display("FAIL win_l2: level=%h score=%h want 2/050", level_bcd, score_bcd); end
        pause = 1'b1; pt = 1'b1; step(50); pt = 1'b0; pause = 1'b0;
        checks++; if (score_bcd !== 12'h150) begin failures++; $display("FAIL win_l2_score: score=%h want 150", score_bcd); end
        wait_done(100);
        checks++; if (win !== 1'b1 || score_bcd !== 12'h150) begin failures++; $display("FAIL win: win=%b score=%h want 1/150", win, score_bcd); end
        st = 1'b1; step(1); st = 1'b0; step(1);
        checks++; if (level_bcd !== 4'h1 || score_bcd !== 12'h000 || {done, win} !== 2'b00 || running !== 1'b1) begin
            failures++; $display("FAIL new_game: level=%h score=%h dw=%b run=%b want 1/000/00/1", level_bcd, score_bcd, {done, win}, running);
        end
        $display("test_final_win: done");
    endtask

    task automatic test_saturation();
        pause = 1'b1; pt = 1'b1; step(499); pt = 1'b0;
        checks++; if (score_bcd !== 12'h998) begin failures++; $display("FAIL sat_pre: score=%h want 998", score_bcd); end
        pt = 1'b1; step(1); pt = 1'b0;
        checks++; if (score_bcd !== 12'h999) begin failures++; $display("FAIL sat_hit: score=%h want 999", score_bcd); end
        pt = 1'b1; step(3); pt = 1'b0;
        checks++; if (score_bcd !== 12'h999 || timer_bcd !== 8'h10) begin failures++; $display("FAIL sat_hold: score=%h timer=%h want 999/10", score_bcd, timer_bcd); end
        pause = 1'b0;
        wait_timer(8'h09, 100);
        pause = 1'b1; step(10);
        checks++; if (timer_bcd !== 8'h09) begin failures++; $display("FAIL pause_hold: timer=%h want 09", timer_bcd); end
        pause = 1'b0;
        $display("test_saturation: done");
    endtask

    task automatic test_rst_mid();
        wait_timer(8'h07, 100);
        rst = 1'b1; step(1); rst = 1'b0;
        checks++; if (score_bcd !== 12'h000 || timer_bcd !== 8'h10 || level_bcd !== 4'h1) begin
            failures++; $display("FAIL rst_mid_vals: score=%h timer=%h level=%h want 000/10/1", score_bcd, timer_bcd, level_bcd);
        end
        checks++; if ({running, done, win} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags: got %b want 000", {running, done, win}); end
        step(3);
        checks++; if (running !== 1'b0 || timer_bcd !== 8'h10) begin failures++; $display("FAIL idle_stays: run=%b timer=%h want 0/10", running, timer_bcd); end
        $display("test_rst_mid: done");
    endtask

    initial begin
        test_reset();
        test_start();
        test_bonus_pause();
        test_final_tick();
        test_level_up();
        test_final_lose();
        test_final_win();
        test_saturation();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
